// File: rtl/rom_stream_if.sv
// rom_stream_if: burst request, ROM read port and output stream of rom_stream_reader.
// ROM_STREAM_LOOP_EN adds the stop request used by looping bursts.
interface rom_stream_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
);
   logic                  start;
   logic [ADDR_WIDTH-1:0] start_addr;
   logic [ADDR_WIDTH:0]   len;
   logic [ADDR_WIDTH-1:0] rom_addr;
   logic                  rom_rd_en;
   logic [DATA_WIDTH-1:0] rom_data;
   logic [DATA_WIDTH-1:0] dout;
   logic                  dout_valid;
   logic                  dout_ready;
   logic                  busy;
   logic                  done;
`ifdef ROM_STREAM_LOOP_EN
   logic                  stop;
`endif
   modport master (
`ifdef ROM_STREAM_LOOP_EN
      input  stop,
`endif
      input  start, start_addr, len, rom_data, dout_ready,
      output rom_addr, rom_rd_en, dout, dout_valid, busy, done
   );
   modport slave (
`ifdef ROM_STREAM_LOOP_EN
      output stop,
`endif
      output start, start_addr, len, rom_data, dout_ready,
      input  rom_addr, rom_rd_en, dout, dout_valid, busy, done
   );
endinterface

// File: rtl/rom_stream_reader.sv
// rom_stream_reader: streams len consecutive ROM words (address wraps) out of a small credit-limited FIFO.
// ROM_STREAM_LOOP_EN: the burst repeats until stop, then drains with a single done.
module rom_stream_reader #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32,
   parameter int RD_LATENCY = 1
) (
   input logic          clk,
   input logic          rst,
   rom_stream_if.master bus
);
   localparam int DEPTH = RD_LATENCY + 2;
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [ADDR_WIDTH:0] ONE = 1;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   state_t                state, state_n;
   logic [ADDR_WIDTH-1:0] addr;
   logic [ADDR_WIDTH:0]   remaining;
   logic [RD_LATENCY-1:0] vsr;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]         wr_ptr, rd_ptr;
   logic [CW-1:0]         count;
   logic                  issue, pop, capture, last_pop, stop_req, last_issue, done_q;
`ifdef ROM_STREAM_LOOP_EN
   logic [ADDR_WIDTH-1:0] base;
   logic [ADDR_WIDTH:0]   total;
   assign stop_req = bus.stop;
   assign last_issue = 1'b0;
`else
   assign stop_req = 1'b0;
   assign last_issue = issue && remaining == ONE;
`endif
   // Words issued but not yet popped never exceed the FIFO depth, so capture can never overflow.
   assign issue = state == RUN && remaining != '0 && int'(count) + $countones(vsr) < DEPTH;
   assign pop = count != '0 && bus.dout_ready;
   assign capture = vsr[RD_LATENCY-1];
   assign last_pop = vsr == '0 && (count == '0 || (count == CW'(1) && pop));
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = bus.start && bus.len != '0 ? RUN : IDLE;
         RUN:     state_n = stop_req || last_issue ? DRAIN : RUN;
         DRAIN:   state_n = last_pop ? IDLE : DRAIN;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_n;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         addr <= '0;
         remaining <= '0;
         vsr <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
         done_q <= 1'b0;
      end else begin
         vsr <= RD_LATENCY'({vsr, issue});
         done_q <= (state == IDLE && bus.start && bus.len == '0) || (state == DRAIN && last_pop);
         if (state == IDLE && bus.start) begin
            addr <= bus.start_addr;
            remaining <= bus.len;
         end else if (issue) begin
            addr <= addr + 1'b1;
            remaining <= remaining - 1'b1;
`ifdef ROM_STREAM_LOOP_EN
            if (remaining == ONE) begin
               addr <= base;
               remaining <= total;
            end
`endif
         end
         if (capture) wr_ptr <= wr_ptr == PW'(DEPTH - 1) ? '0 : wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr == PW'(DEPTH - 1) ? '0 : rd_ptr + 1'b1;
         count <= count + CW'(capture) - CW'(pop);
      end
`ifdef ROM_STREAM_LOOP_EN
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         base <= '0;
         total <= '0;
      end else if (state == IDLE && bus.start) begin
         base <= bus.start_addr;
         total <= bus.len;
      end
`endif
   always_ff @(posedge clk)
      if (capture) mem[wr_ptr] <= bus.rom_data;
   assign bus.rom_addr = addr;
   assign bus.rom_rd_en = issue;
   assign bus.dout_valid = count != '0;
   assign bus.dout = count != '0 ? mem[rd_ptr] : '0;
   assign bus.busy = state != IDLE;
   assign bus.done = done_q;
endmodule

// File: tb/tb_rom_stream_reader.sv
// tb_rom_stream_reader: random bursts checked every cycle against a stream-level model, plus directed corners.
module tb_rom_stream_reader;
   localparam int AW = 10;
   localparam int DW = 32;
   localparam int LAT = 3;
   localparam int NW = 1 << AW;
`ifdef ROM_STREAM_LOOP_EN
   localparam bit LOOP = 1'b1;
`else
   localparam bit LOOP = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   rom_stream_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
   rom_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(LAT)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );
   logic [DW-1:0] rom_mem [NW];
   logic [DW-1:0] rp [LAT];
   always @(posedge clk) begin
      if (bus.rom_rd_en) rp[0] <= rom_mem[bus.rom_addr];
      for (int i = 1; i < LAT; i++) rp[i] <= rp[i-1];
   end
   assign bus.rom_data = rp[LAT-1];

   int checks = 0, errors = 0, rmode = 0;
   bit mdl_busy = 0, exp_done = 0, stop_seen = 0, hold_prev = 0, throttled = 0;
   int base = 0, blen = 1, n_iss = 0, n_pop = 0, done_cnt = 0, rd_total = 0, wait_t = 0;
   logic [DW-1:0] prev_dout;
   int addr_log [64];
   logic [DW-1:0] pop_log [64];
   int exp_wrap [4] = '{1022, 1023, 0, 1};
   int exp_loop [7] = '{4, 5, 6, 4, 5, 6, 4};

   function automatic int word_addr(int j);
      return (base + j % blen) % NW;
   endfunction

   task automatic chk(input bit ok, input string name, input longint act, input longint exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cycle_check();
      bit was_busy, pop, rd;
      if (rst) begin
         chk({bus.dout, bus.dout_valid, bus.rom_addr, bus.rom_rd_en, bus.busy, bus.done} == '0, "reset_outputs",
             {bus.rom_addr, bus.dout_valid, bus.rom_rd_en, bus.busy, bus.done}, 0);
         mdl_busy = 0; exp_done = 0; hold_prev = 0; stop_seen = 0; n_iss = 0; n_pop = 0;
         return;
      end
      chk(bus.done == exp_done, "done", bus.done, exp_done);
      chk(bus.busy == mdl_busy, "busy", bus.busy, mdl_busy);
      if (hold_prev) chk(bus.dout_valid && bus.dout == prev_dout, "hold_stable", bus.dout, prev_dout);
      chk(n_iss - n_pop <= LAT + 2, "outstanding", n_iss - n_pop, LAT + 2);
      if (bus.done) done_cnt++;
      rd = bus.rom_rd_en;
      pop = bus.dout_valid && bus.dout_ready;
      if (mdl_busy && !rd && !stop_seen && (LOOP || n_iss < blen)) throttled = 1;
      if (pop) begin
         chk(mdl_busy && n_pop < n_iss && bus.dout == rom_mem[word_addr(n_pop)], "dout", bus.dout, rom_mem[word_addr(n_pop)]);
         if (n_pop < 64) pop_log[n_pop] = bus.dout;
         n_pop++;
      end
      if (rd) begin
         rd_total++;
         chk(mdl_busy && !stop_seen && (LOOP || n_iss < blen) && int'(bus.rom_addr) == word_addr(n_iss), "rd_addr",
             bus.rom_addr, word_addr(n_iss));
         if (n_iss < 64) addr_log[n_iss] = int'(bus.rom_addr);
         n_iss++;
      end
      was_busy = mdl_busy;
      exp_done = 0;
`ifdef ROM_STREAM_LOOP_EN
      if (mdl_busy && bus.stop) stop_seen = 1;
`endif
      if (mdl_busy && pop && (LOOP ? stop_seen && n_pop == n_iss : n_pop == blen)) begin
         mdl_busy = 0;
         exp_done = 1;
      end
      if (!was_busy && bus.start) begin
         if (bus.len == '0) exp_done = 1;
         else begin
            mdl_busy = 1; base = int'(bus.start_addr); blen = int'(bus.len);
            n_iss = 0; n_pop = 0; stop_seen = 0;
         end
      end
      hold_prev = bus.dout_valid && !bus.dout_ready;
      prev_dout = bus.dout;
   endtask

   task automatic step();
      @(negedge clk);
      cycle_check();
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.dout_ready = rmode == 0 ? 1'b1 : rmode == 1 ? !bus.dout_ready : 1'($urandom_range(0, 3) != 0);
   endtask

   task automatic run_burst(input int sa, input int n, input bit poke);
      bus.start = 1'b1;
      bus.start_addr = AW'(sa);
      bus.len = (AW + 1)'(n);
      step();
      wait_t = 0;
      while ((mdl_busy || bus.busy) && wait_t < 3000) begin
         if (poke && $urandom_range(0, 5) == 0) begin
            bus.start = 1'b1;
            bus.start_addr = AW'($urandom);
            bus.len = (AW + 1)'($urandom_range(0, 20));
         end
`ifdef ROM_STREAM_LOOP_EN
         bus.stop = n_pop >= 2 * n + 1;
`endif
         step();
         wait_t++;
      end
`ifdef ROM_STREAM_LOOP_EN
      bus.stop = 1'b0;
`endif
      step();
      if (wait_t >= 3000) begin
         chk(0, "burst_timeout", wait_t, 3000);
         rst = 1'b1; step(); rst = 1'b0; step();
      end
   endtask

   initial begin
      int d0, r0;
      for (int i = 0; i < NW; i++) rom_mem[i] = ($urandom() & 32'hFFFF_0000) | DW'(i);
      bus.start = 1'b0; bus.start_addr = '0; bus.len = '0; bus.dout_ready = 1'b1;
`ifdef ROM_STREAM_LOOP_EN
      bus.stop = 1'b0;
`endif
      step(); step();
      rst = 1'b0;
      step();
      // first word lands RD_LATENCY+1 edges after the start edge, then one word per cycle
      rmode = 0;
      bus.start = 1'b1; bus.start_addr = '0; bus.len = 11'd8;
      step();
      for (int i = 1; i <= LAT + 1; i++) begin
         step();
         chk(bus.dout_valid == (i == LAT + 1), "first_valid", bus.dout_valid, i == LAT + 1);
      end
      for (int k = 0; k < 8; k++) begin
         chk(bus.dout_valid && bus.dout[15:0] == 16'(k), "stream_word", bus.dout[15:0], k);
         step();
      end
`ifndef ROM_STREAM_LOOP_EN
      chk(bus.done && !bus.busy && !bus.dout_valid, "done_after_last", {bus.done, bus.busy, bus.dout_valid}, 3'b100);
      step();
      chk(!bus.done, "done_one_cycle", bus.done, 0);
`endif
      wait_t = 0;
      while ((mdl_busy || bus.busy) && wait_t < 200) begin
`ifdef ROM_STREAM_LOOP_EN
         bus.stop = 1'b1;
`endif
         step();
         wait_t++;
      end
`ifdef ROM_STREAM_LOOP_EN
      bus.stop = 1'b0;
`endif
      chk(wait_t < 200, "first_burst_end", wait_t, 200);
      step();
      // toggling ready forces throttling of issues
      rmode = 1; throttled = 0;
      run_burst($urandom_range(0, NW - 1), 16, 0);
      chk(throttled, "throttle", throttled, 1);
`ifndef ROM_STREAM_LOOP_EN
      chk(n_pop == 16, "words_toggle", n_pop, 16);
`endif
      rmode = 0;
      run_burst(1022, 4, 0);
      for (int k = 0; k < 4; k++) chk(addr_log[k] == exp_wrap[k], "wrap_addr", addr_log[k], exp_wrap[k]);
      d0 = done_cnt; r0 = rd_total;
      run_burst(7, 0, 0);
      step();
      chk(done_cnt - d0 == 1, "len0_done", done_cnt - d0, 1);
      chk(rd_total == r0, "len0_no_read", rd_total - r0, 0);
      // abort mid-burst
      bus.start = 1'b1; bus.start_addr = AW'($urandom); bus.len = 11'd10;
      step();
      wait_t = 0;
      while (n_pop < 3 && wait_t < 50) begin step(); wait_t++; end
      chk(n_pop == 3, "pre_abort_pops", n_pop, 3);
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      d0 = done_cnt;
      repeat (8) step();
      chk(done_cnt == d0, "no_done_after_abort", done_cnt - d0, 0);
      chk(!bus.dout_valid && !bus.busy, "idle_after_abort", {bus.dout_valid, bus.busy}, 0);
      run_burst(5, 2, 0);
      chk(pop_log[0][15:0] == 16'd5, "post_abort_w0", pop_log[0][15:0], 5);
      chk(pop_log[1][15:0] == 16'd6, "post_abort_w1", pop_log[1][15:0], 6);
`ifndef ROM_STREAM_LOOP_EN
      chk(n_pop == 2, "post_abort_count", n_pop, 2);
`else
      d0 = done_cnt;
      run_burst(4, 3, 0);
      for (int k = 0; k < 7; k++) chk(pop_log[k][15:0] == 16'(exp_loop[k]), "loop_word", pop_log[k][15:0], exp_loop[k]);
      chk(done_cnt - d0 == 1, "loop_done", done_cnt - d0, 1);
`endif
      for (int t = 0; t < 25; t++) begin
         rmode = $urandom_range(0, 2);
         run_burst($urandom_range(0, NW - 1), $urandom_range(0, 40), 1);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/rom_stream_reader.md
ROM_STREAM_READER -- requirements
Module: rom_stream_reader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, ROM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, ROM data width.
REQ-003 SHALL have parameter RD_LATENCY, default 1, ROM read latency in clk cycles, legal 1..3 (1 = no output reg, 2 = output reg, 3 = output reg + fabric reg).
REQ-004 SHALL have ports: clk  input  1  sole clock, rising edge; rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  burst request, sampled only in IDLE.
REQ-006 SHALL have port start_addr  input  ADDR_WIDTH  first ROM address, sampled with start.
REQ-007 SHALL have port len  input  ADDR_WIDTH+1  number of words, sampled with start.
REQ-008 SHALL have port rom_addr  output  ADDR_WIDTH  address to ROM addr.
REQ-009 SHALL have port rom_rd_en  output  1  read issue qualifier, drives ROM clk_en.
REQ-010 SHALL have port rom_data  input  DATA_WIDTH  from ROM rd_data.
REQ-011 SHALL have ports: dout  output  DATA_WIDTH  stream data; dout_valid  output  1; dout_ready  input  1.
REQ-012 SHALL have ports: busy  output  1  state not IDLE; done  output  1  one-cycle end-of-burst pulse.

Function
REQ-013 SHALL implement states IDLE, RUN, DRAIN.
REQ-014 IDLE: start=1 with len!=0 SHALL latch start_addr/len and go to RUN; with len=0 SHALL pulse done next cycle, issue no read, stay IDLE.
REQ-015 RUN: SHALL issue a read (rom_rd_en=1, rom_addr=current address) in any cycle where remaining>0 and (fifo_count + in_flight) < RD_LATENCY+2.
REQ-016 Each issue SHALL increment the address modulo 2^ADDR_WIDTH (wrap from all-ones to 0) and decrement remaining.
REQ-017 RUN SHALL go to DRAIN in the cycle the last read is issued.
REQ-018 DRAIN SHALL go to IDLE and pulse done for exactly one cycle when in_flight=0 and the final word is popped.
REQ-019 Returned data SHALL be captured into an internal FIFO of depth RD_LATENCY+2 exactly RD_LATENCY cycles after its issue cycle, tracked by an RD_LATENCY-deep valid shift register; the FIFO SHALL never overflow.
REQ-020 dout_valid SHALL equal FIFO not empty; pop on dout_valid & dout_ready; dout/dout_valid SHALL hold stable while dout_valid & !dout_ready.
REQ-021 Words SHALL leave in address order, none dropped or duplicated.
REQ-022 With dout_ready held 1, throughput SHALL be one word per cycle, first dout_valid RD_LATENCY+1 cycles after the edge sampling start.
REQ-023 start while busy SHALL be ignored; rom_rd_en SHALL be 0 outside RUN.
REQ-024 A burst crossing address wrap (e.g. start_addr=1022, len=4, ADDR_WIDTH=10) SHALL read 1022,1023,0,1.

Reset
REQ-025 rst=1 SHALL immediately force state IDLE, flush FIFO and in-flight tags, and drive dout=0, dout_valid=0, rom_addr=0, rom_rd_en=0, busy=0, done=0.
REQ-026 Reset mid-burst SHALL abort: no done pulse, data returning after reset release discarded.

Configuration
REQ-027 Macro ROM_STREAM_LOOP_EN defined SHALL add input port stop (1 bit); in RUN, after the last address, address reloads start_addr and remaining reloads len (continuous loop); stop=1 sampled in RUN SHALL go to DRAIN after the current issue with single done at end.
REQ-028 Macro ROM_STREAM_LOOP_EN undefined SHALL omit stop and perform single-pass bursts only.

Verification
REQ-029 RD_LATENCY=1, start_addr=0, len=8, dout_ready=1 -> dout = ROM[0..7] on 8 consecutive cycles, first valid 2 cycles after start, done 1 cycle after last pop.
REQ-030 RD_LATENCY=3, len=16, dout_ready toggling 1/0 -> all 16 words in order, no loss, FIFO count never exceeds 5, rom_rd_en throttled.
REQ-031 start_addr=1022, len=4 -> addresses 1022,1023,0,1 on rom_addr.
REQ-032 len=0 -> done single pulse, rom_rd_en never high, busy stays 0.
REQ-033 rst pulsed after 3 of 10 words -> all outputs 0, no done, next burst start_addr=5, len=2 returns ROM[5],ROM[6] only.
REQ-034 ROM_STREAM_LOOP_EN, start_addr=4, len=3, stop after 7 words popped -> dout sequence ROM[4,5,6,4,5,6,4...] ending cleanly in order, one done.
